// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encodings, counter sizing
// helpers and the width of the saturating event counts.
package reset_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned COUNT_W = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  localparam logic [STATE_W-1:0] ST_CMRST    = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAITLOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABLE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_HOLD     = 3'd3;
  localparam logic [STATE_W-1:0] ST_RUN      = 3'd4;

  function automatic int unsigned max_cycles(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned d
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold 0 .. max_cycles-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_cycles_in);
    return (max_cycles_in <= 2) ? 1 : $clog2(max_cycles_in);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to zero; shared with
// LED and button input paths, hence the width parameter.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / recovery sequencer: pulses the clock manager reset, waits for a
// stable lock, holds the core in reset, then runs; re-kicks on timeout or loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES         = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CM_RESET_CYCLES     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cm_locked,
  output logic               cm_reset,
  output logic               sys_reset,
  output logic [STATE_W-1:0] state,
  output logic [COUNT_W-1:0] retry_count,
  output logic [COUNT_W-1:0] loss_count
);

  localparam int unsigned CNT_MAX = max_cycles(LOCK_STABLE_CYCLES, HOLD_CYCLES,
                                               LOCK_TIMEOUT_CYCLES, CM_RESET_CYCLES);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] CR_LAST = CNT_W'(CM_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic locked_s;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] retry_q, retry_d;
  logic [COUNT_W-1:0] loss_q, loss_d;
  logic               cm_reset_q, cm_reset_d;
  logic               sys_reset_q, sys_reset_d;

  sync2 #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk  (clock),
    .rst_n(reset),
    .d    (cm_locked),
    .q    (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      ST_CMRST: begin
        if (cnt_q == CR_LAST) state_d = ST_WAITLOCK;
      end
      ST_WAITLOCK: begin
        // Lock is tested first so it wins over a timeout in the same cycle.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LT_LAST) begin
          state_d = ST_CMRST;
          retry_d = sat_inc(retry_q);
        end
      end
      ST_STABLE: begin
        if (!locked_s)             state_d = ST_WAITLOCK;
        else if (cnt_q == LS_LAST) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!locked_s)             state_d = ST_WAITLOCK;
        else if (cnt_q == HD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_CMRST;
          loss_d  = sat_inc(loss_q);
        end
      end
      default: state_d = ST_CMRST;
    endcase

    // Cleared on every state change; parks at all-ones while RUN idles.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;

    cm_reset_d  = (state_d == ST_CMRST);
    sys_reset_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CMRST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      cm_reset_q  <= 1'b1;
      sys_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      cm_reset_q  <= cm_reset_d;
      sys_reset_q <= sys_reset_d;
    end
  end

  assign state       = state_q;
  assign cm_reset    = cm_reset_q;
  assign sys_reset   = sys_reset_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-up and recovery sequencer sitting between the board clock input, the clock manager and the system core. Resets the clock manager, waits for a stable lock, then releases the core reset after a fixed hold. It re-kicks the clock manager on lock timeout or on loss of lock in operation, and reports state and saturating event counts for the board LEDs.

## Interface
Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before the hold phase starts.
- HOLD_CYCLES, 16: cycles the core reset stays asserted after lock is declared stable.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAITLOCK before the clock manager is reset again.
- CM_RESET_CYCLES, 4: width of the cm_reset pulse, in cycles.
- All parameters are ≥ 1.

Ports:
- clock  in  1  raw board clock; this block never uses a clock manager output.
- reset  in  1  asynchronous, active-low.
- cm_locked  in  1  lock from the clock manager; asynchronous to clock.
- cm_reset  out  1  active-high reset to the clock manager.
- sys_reset  out  1  active-low reset to the system core; high only in RUN.
- state  out  3  current state encoding.
- retry_count  out  4  lock timeouts; saturates at 15.
- loss_count  out  4  lock losses while in RUN; saturates at 15.

## Operation
- cm_locked passes through a 2-flop synchronizer to give locked_s. Both flops reset to 0.
- One shared cycle counter, wide enough for the largest parameter. It is cleared on every state entry.
- States (encoding): CMRST=0, WAITLOCK=1, STABLE=2, HOLD=3, RUN=4. Codes 5–7 go to CMRST.
- CMRST: cm_reset=1. Go to WAITLOCK when counter == CM_RESET_CYCLES-1.
- WAITLOCK:
  - locked_s=1 → STABLE.
  - Otherwise, when counter == LOCK_TIMEOUT_CYCLES-1 → CMRST and retry_count+1.
  - If both conditions hold in the same cycle, the lock wins: go to STABLE, no retry increment.
- STABLE:
  - locked_s=0 → WAITLOCK. No count increment.
  - Otherwise go to HOLD when counter == LOCK_STABLE_CYCLES-1.
- HOLD:
  - locked_s=0 → WAITLOCK.
  - Otherwise go to RUN when counter == HOLD_CYCLES-1.
- RUN: sys_reset=1. locked_s=0 → CMRST and loss_count+1.
- Counts saturate at 15 and are never wrapped. They are cleared only by reset.
- Outputs cm_reset, sys_reset and state are registered, loaded from the next-state value. They always match the state register and are glitch-free.

Reset:
- While reset=0: state=CMRST, counter=0, synchronizer=0, cm_reset=1, sys_reset=0, state=0, retry_count=0, loss_count=0.
- Assertion takes effect immediately, with no clock needed, including in RUN.
- After deassertion, CMRST lasts exactly CM_RESET_CYCLES edges.

## Timing
- Synchronizer latency: 2 edges.
- cm_locked first sampled high at edge e0 while in WAITLOCK:
  - STABLE is entered at e0+2.
  - HOLD is entered at e0+2+LOCK_STABLE_CYCLES.
  - sys_reset rises at e0+2+LOCK_STABLE_CYCLES+HOLD_CYCLES.
- Lock dropped in RUN, first sampled low at edge e0: sys_reset falls and cm_reset rises at e0+2.
- Timeout: WAITLOCK entered at edge w → CMRST at w+LOCK_TIMEOUT_CYCLES.
- A glitch on cm_locked shorter than one clock period may be missed. This is acceptable.

## Structure
- Shared package reset_seq_pkg holds the state encodings, the counter width function, and the count width (4).
- Sub-module sync2: 2-flop synchronizer with asynchronous active-low reset and reset value 0. It is reused elsewhere for LED and button inputs.
- The FSM, counter and saturating counters live in reset_sequencer itself.

## Test plan
All scenarios use parameters LS=8, HD=4, LT=32, CR=4.
- Power-up, cm_locked rises 10 cycles after reset release:
  - cm_reset high for exactly 4 edges.
  - sys_reset rises 14 edges after the first high sample of cm_locked.
  - state sequence 0,1,2,3,4.
- cm_locked held low:
  - A CMRST re-entry every 36 edges (4 CMRST + 32 WAITLOCK).
  - retry_count increments 1…15, then stays at 15 after the 16th timeout.
- cm_locked drops for 3 cycles during STABLE (counter=5):
  - Return to WAITLOCK with no count change.
  - Full 8-cycle STABLE restarts on relock; sys_reset stays 0.
- Lock lost in RUN:
  - sys_reset falls 2 edges after the first low sample.
  - cm_reset is asserted for 4 edges and loss_count=1.
  - On relock, the full sequence repeats.
- Lock asserted on the same cycle the timeout expires: enter STABLE, retry_count unchanged.
- reset pulsed low mid-HOLD and mid-RUN, with no clock edge during the pulse:
  - Outputs take their reset values immediately (sys_reset=0, cm_reset=1, counts=0).
